myproject_mul_pipe_rs: RTL
==========================

// Module: myproject_mul_pipe_rs
//
// PURPOSE
// Parametrised pipelined signed multiplier for the dense/conv datapath. It generalises the fixed
// 16s x 7s -> 23 combinational DSP multiply by adding configurable operand and result widths and
// a configurable pipeline depth. It also adds valid/clock-enable flow control, arithmetic
// right-shift with optional round-half-up, and saturate-or-wrap output narrowing.
// Sits between the weight/activation fetch and the accumulator trees; maps onto DSP48 slices.
//
// PARAMETERS
// DIN0_WIDTH  16  signed width of din0 (activation), 2..25
// DIN1_WIDTH  7   signed width of din1 (weight), 2..18
// DOUT_WIDTH  23  signed width of dout, 2..DIN0_WIDTH+DIN1_WIDTH
// NUM_STAGE   2   pipeline depth in cycles, 1..4
// SHIFT       0   arithmetic right shift applied to the full product, 0..DIN0_WIDTH+DIN1_WIDTH-2
// ROUND       0   1: round half toward +inf before shift (adds 2^(SHIFT-1)); ignored when SHIFT=0
// SAT         1   1: clamp to DOUT range on overflow; 0: keep low DOUT_WIDTH bits (wrap)
//
// PORTS
// ap_clk    in   1           clock, rising edge
// ap_rst_n  in   1           asynchronous active-low reset
// ce        in   1           clock enable; 0 freezes the whole pipeline
// din_vld   in   1           din0/din1 valid this cycle (sampled when ce=1)
// din0      in   DIN0_WIDTH  signed operand A
// din1      in   DIN1_WIDTH  signed operand B
// dout_vld  out  1           dout/dout_ovf valid
// dout      out  DOUT_WIDTH  signed scaled result
// dout_ovf  out  1           1 when the scaled result did not fit DOUT_WIDTH (SAT or wrap)
//
// BEHAVIOUR
// - One clock, ap_clk; ap_rst_n is asynchronous active-low. While it is low, every stage data
//   and valid register clears. Outputs read dout=0, dout_vld=0, dout_ovf=0.
// - Arithmetic: P = DIN0_WIDTH+DIN1_WIDTH; prod = din0*din1, full P-bit signed (never overflows).
//   r = (prod + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, computed in P+1 bits.
//   The extra bit absorbs rounding carry at the max-product corner.
//   If r lies within [-2^(DOUT_WIDTH-1), 2^(DOUT_WIDTH-1)-1]: dout=r, dout_ovf=0.
//   Otherwise dout_ovf=1. With SAT=1, dout is clamped to the nearest bound.
//   With SAT=0, dout = r[DOUT_WIDTH-1:0].
// - Latency: with ce held 1, a sample accepted at edge k (din_vld=1) appears on dout/dout_vld
//   after edge k+NUM_STAGE-1, i.e. NUM_STAGE register stages. Throughput is one sample per
//   enabled cycle; back-to-back accepts are allowed.
// - din_vld=0 samples travel as bubbles. dout_vld=0 for them.
//   dout/dout_ovf hold their last valid values; they do not update on bubbles.
// - ce=0: no register (data or valid) changes; outputs hold exactly. Inputs are ignored that
//   cycle. Latency counts enabled cycles only.
// - Stage allocation is free (e.g. multiply in stage 1, round/sat in the last stage), provided
//   output timing above is exact. NUM_STAGE=1 registers only the final result.
// - Reset asserted mid-operation: all in-flight samples are discarded. No dout_vld pulse occurs
//   for them after reset release. First valid output follows the first post-reset accept by
//   NUM_STAGE enabled cycles.
// - No internal state survives beyond NUM_STAGE; no FSM; no backpressure beyond ce.
//
// TESTING
// 1 Defaults, din0=-32768 din1=-64 vld, ce=1 -> dout=23'h200000 (2097152), ovf=0, after 2 edges.
// 2 DOUT=16 SHIFT=6 ROUND=1 SAT=1, din0=-32768 din1=-64 -> dout=32767, ovf=1.
//   Same with SAT=0 -> dout=16'h8000, ovf=1.
// 3 Same config, rounding: (3,11)->1; (1,31)->0; (-1,32)->0; (-1,33)->-1; all with ovf=0.
// 4 Defaults, 100 random back-to-back vld samples with ce=1 -> outputs match model in order,
//   one per cycle, latency 2, no dropped or duplicated dout_vld.
// 5 Random ce toggling (~50%) with random din_vld -> output stream equals model. Outputs are
//   frozen on every ce=0 cycle, and latency counts enabled edges only.
// 6 Assert ap_rst_n low asynchronously (mid-cycle) with 2 samples in flight -> outputs 0 at once.
//   After release, no dout_vld until a new accept + NUM_STAGE edges.

Source files
------------

// File: rtl/myproject_mul_pipe_rs.sv
// Pipelined signed multiplier with arithmetic scale, optional round-half-up
// and saturate-or-wrap narrowing; valid and clock-enable flow control.
module myproject_mul_pipe_rs #(
    parameter int DIN0_WIDTH = 16,
    parameter int DIN1_WIDTH = 7,
    parameter int DOUT_WIDTH = 23,
    parameter int NUM_STAGE  = 2,
    parameter int SHIFT      = 0,
    parameter int ROUND      = 0,
    parameter int SAT        = 1
) (
    input  logic                         ap_clk,
    input  logic                         ap_rst_n,
    input  logic                         ce,
    input  logic                         din_vld,
    input  logic signed [DIN0_WIDTH-1:0] din0,
    input  logic signed [DIN1_WIDTH-1:0] din1,
    output logic                         dout_vld,
    output logic signed [DOUT_WIDTH-1:0] dout,
    output logic                         dout_ovf
);

    localparam int P   = DIN0_WIDTH + DIN1_WIDTH;
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam int HW  = P - DOUT_WIDTH + 2;

    localparam logic signed [P:0] RND_ADD =
        (ROUND != 0 && SHIFT > 0) ? ((P+1)'(1) << RSH) : '0;
    localparam logic signed [DOUT_WIDTH-1:0] DMAX =
        {1'b0, {(DOUT_WIDTH-1){1'b1}}};
    localparam logic signed [DOUT_WIDTH-1:0] DMIN =
        {1'b1, {(DOUT_WIDTH-1){1'b0}}};

    logic signed [P-1:0] prod_c;
    logic signed [P-1:0] fin_prod;
    logic                fin_vld;

    assign prod_c = P'(din0) * P'(din1);

    generate
        if (NUM_STAGE == 1) begin : g_direct
            assign fin_prod = prod_c;
            assign fin_vld  = din_vld;
        end else begin : g_pipe
            localparam int D = NUM_STAGE - 1;

            logic signed [P-1:0] prod_q [D];
            logic        [D-1:0] vld_q;

            // Stage 0 only loads on valid samples to avoid toggling on bubbles.
            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    for (int i = 0; i < D; i++) begin
                        prod_q[i] <= '0;
                    end
                    vld_q <= '0;
                end else if (ce) begin
                    if (din_vld) begin
                        prod_q[0] <= prod_c;
                    end
                    vld_q[0] <= din_vld;
                    for (int i = 1; i < D; i++) begin
                        prod_q[i] <= prod_q[i-1];
                        vld_q[i]  <= vld_q[i-1];
                    end
                end
            end

            assign fin_prod = prod_q[D-1];
            assign fin_vld  = vld_q[D-1];
        end
    endgenerate

    logic signed [P:0]            ext_c;
    logic signed [P:0]            sum_c;
    logic signed [P:0]            r_c;
    logic                         fits_c;
    logic signed [DOUT_WIDTH-1:0] dout_d;
    logic                         ovf_d;

    // One guard bit keeps the rounding carry of the largest product.
    always_comb begin
        ext_c  = {fin_prod[P-1], fin_prod};
        sum_c  = ext_c + RND_ADD;
        r_c    = sum_c >>> SHIFT;
        fits_c = (r_c[P:DOUT_WIDTH-1] == {HW{r_c[P]}});
        ovf_d  = !fits_c;
        dout_d = r_c[DOUT_WIDTH-1:0];
        if (!fits_c && SAT != 0) begin
            dout_d = r_c[P] ? DMIN : DMAX;
        end
    end

    logic                         vld_out_q;
    logic signed [DOUT_WIDTH-1:0] dout_q;
    logic                         ovf_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            vld_out_q <= 1'b0;
            dout_q    <= '0;
            ovf_q     <= 1'b0;
        end else if (ce) begin
            vld_out_q <= fin_vld;
            if (fin_vld) begin
                dout_q <= dout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign dout_vld = vld_out_q;
    assign dout     = dout_q;
    assign dout_ovf = ovf_q;

endmodule
